// File: rtl/perf_counter_bank.sv
// Bank of memory-mapped event counters: per-channel cycle or run counting,
// run-length threshold, wrap/saturate overflow with a sticky flag.
module perf_counter_bank #(
    parameter int          NUM_CH    = 9,
    parameter int          WIDTH     = 16,
    parameter logic [15:0] BASE_ADDR = 16'hFF00,
    parameter bit          SATURATE  = 1'b1,
    parameter int          THRESH_W  = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [NUM_CH-1:0] events,
    input  logic              freeze,
    input  logic [15:0]       bus_addr,
    input  logic              bus_read,
    input  logic              bus_write,
    input  logic [15:0]       bus_wdata,
    output logic              bus_hit,
    output logic              bus_resp,
    output logic [15:0]       bus_rdata
);

    localparam logic [15:0] BASE_WORD = {1'b0, BASE_ADDR[15:1]};
    localparam logic [15:0] NCH       = 16'(NUM_CH);
    localparam logic [15:0] NREG      = 16'(2 * NUM_CH);

    logic [15:0] word_off;
    logic [15:0] sel_idx;
    logic [4:0]  sel_ch;
    logic        sel_cfg;
    logic        wr_acc;
    logic        req_acc;
    logic [15:0] rd_mux;
    logic        unused_bits;

    // Addresses below the base wrap to large offsets and so fall outside the window.
    assign word_off = {1'b0, bus_addr[15:1]} - BASE_WORD;
    assign bus_hit  = (word_off < NREG);
    assign sel_cfg  = (word_off >= NCH);
    assign sel_idx  = sel_cfg ? (word_off - NCH) : word_off;
    assign sel_ch   = sel_idx[4:0];
    assign wr_acc   = bus_hit && bus_write;
    assign req_acc  = bus_hit && (bus_read || bus_write);

    assign unused_bits = ^{bus_addr[0], sel_idx[15:5], bus_wdata};

    logic [15:0] cnt_view [NUM_CH];
    logic [15:0] cfg_view [NUM_CH];

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic [WIDTH-1:0]    cnt_reg;
            logic [THRESH_W-1:0] thresh_reg;
            logic [THRESH_W-1:0] run_reg;
            logic [1:0]          mode_reg;
            logic                ovf_reg;
            logic                sel;
            logic                cnt_wr;
            logic                cfg_wr;
            logic                inc;
            logic                at_max;

            assign sel    = (sel_ch == 5'(gi));
            assign cnt_wr = wr_acc && sel && !sel_cfg;
            assign cfg_wr = wr_acc && sel && sel_cfg;
            assign at_max = &cnt_reg;
            assign inc    = !freeze && events[gi] &&
                            ((mode_reg == 2'b00) ||
                             (mode_reg == 2'b01 && run_reg == thresh_reg));

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    cnt_reg    <= '0;
                    thresh_reg <= '0;
                    run_reg    <= '0;
                    mode_reg   <= 2'b00;
                    ovf_reg    <= 1'b0;
                end else begin
                    // A bus load wins over an increment due in the same cycle.
                    if (cnt_wr) begin
                        cnt_reg <= bus_wdata[WIDTH-1:0];
                    end else if (inc) begin
                        if (!at_max) begin
                            cnt_reg <= cnt_reg + 1'b1;
                        end else if (!SATURATE) begin
                            cnt_reg <= '0;
                        end
                    end

                    if (cfg_wr) begin
                        thresh_reg <= bus_wdata[THRESH_W-1:0];
                        mode_reg   <= bus_wdata[13:12];
                    end

                    if (inc && !cnt_wr && at_max) begin
                        ovf_reg <= 1'b1;
                    end else if (cfg_wr && bus_wdata[15]) begin
                        ovf_reg <= 1'b0;
                    end

                    if (!freeze) begin
                        if (!events[gi]) begin
                            run_reg <= '0;
                        end else if (!(&run_reg)) begin
                            run_reg <= run_reg + 1'b1;
                        end
                    end
                end
            end

            assign cnt_view[gi] = 16'(cnt_reg);
            assign cfg_view[gi] = {ovf_reg, 1'b0, mode_reg, 12'h000} | 16'(thresh_reg);
        end
    endgenerate

    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (sel_ch == 5'(i)) begin
                rd_mux = sel_cfg ? cfg_view[i] : cnt_view[i];
            end
        end
    end

    // Response carries the value seen before this edge's update.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus_resp  <= 1'b0;
            bus_rdata <= '0;
        end else begin
            bus_resp <= req_acc;
            if (req_acc) begin
                bus_rdata <= rd_mux;
            end
        end
    end

endmodule

// File: tb/tb_perf_counter_bank.sv
// Directed bench for perf_counter_bank: default bank plus two single-channel
// 4-bit instances (saturating and wrapping) sharing a small bus.
module tb_perf_counter_bank;

    logic        clk;
    logic        reset_n;
    logic [8:0]  events;
    logic        freeze;
    logic [15:0] bus_addr;
    logic        bus_read;
    logic        bus_write;
    logic [15:0] bus_wdata;
    logic        bus_hit;
    logic        bus_resp;
    logic [15:0] bus_rdata;

    logic [0:0]  s_events;
    logic [15:0] s_addr;
    logic        s_read;
    logic        s_write;
    logic [15:0] s_wdata;
    logic        sat_hit, sat_resp, wrp_hit, wrp_resp;
    logic [15:0] sat_rdata, wrp_rdata;

    int checks = 0;
    int errors = 0;

    perf_counter_bank u_dut (
        .clk(clk), .reset_n(reset_n), .events(events), .freeze(freeze),
        .bus_addr(bus_addr), .bus_read(bus_read), .bus_write(bus_write),
        .bus_wdata(bus_wdata), .bus_hit(bus_hit), .bus_resp(bus_resp),
        .bus_rdata(bus_rdata)
    );

    perf_counter_bank #(.NUM_CH(1), .WIDTH(4), .SATURATE(1'b1)) u_sat (
        .clk(clk), .reset_n(reset_n), .events(s_events), .freeze(1'b0),
        .bus_addr(s_addr), .bus_read(s_read), .bus_write(s_write),
        .bus_wdata(s_wdata), .bus_hit(sat_hit), .bus_resp(sat_resp),
        .bus_rdata(sat_rdata)
    );

    perf_counter_bank #(.NUM_CH(1), .WIDTH(4), .SATURATE(1'b0)) u_wrp (
        .clk(clk), .reset_n(reset_n), .events(s_events), .freeze(1'b0),
        .bus_addr(s_addr), .bus_read(s_read), .bus_write(s_write),
        .bus_wdata(s_wdata), .bus_hit(wrp_hit), .bus_resp(wrp_resp),
        .bus_rdata(wrp_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic bus_op(input logic [15:0] addr, input logic rd, input logic wr,
                          input logic [15:0] wdata, output logic hit,
                          output logic resp, output logic [15:0] rdata);
        @(negedge clk);
        bus_addr  = addr;
        bus_read  = rd;
        bus_write = wr;
        bus_wdata = wdata;
        #1 hit = bus_hit;
        @(negedge clk);
        resp      = bus_resp;
        rdata     = bus_rdata;
        bus_read  = 1'b0;
        bus_write = 1'b0;
        $display("bus addr=%h rd=%0b wr=%0b wdata=%h -> hit=%0b resp=%0b rdata=%h",
                 addr, rd, wr, wdata, hit, resp, rdata);
    endtask

    task automatic rd_chk(input string tag, input logic [15:0] addr, input logic [15:0] exp);
        logic h, r;
        logic [15:0] d;
        bus_op(addr, 1'b1, 1'b0, 16'h0000, h, r, d);
        check({tag, " resp"}, 16'(r), 16'h0001);
        check(tag, d, exp);
    endtask

    task automatic wr_op(input logic [15:0] addr, input logic [15:0] data);
        logic h, r;
        logic [15:0] d;
        bus_op(addr, 1'b0, 1'b1, data, h, r, d);
    endtask

    task automatic s_op(input logic [15:0] addr, input logic rd, input logic wr,
                        input logic [15:0] wdata);
        @(negedge clk);
        s_addr  = addr;
        s_read  = rd;
        s_write = wr;
        s_wdata = wdata;
        @(negedge clk);
        s_read  = 1'b0;
        s_write = 1'b0;
        $display("sbus addr=%h rd=%0b wr=%0b -> sat resp=%0b rdata=%h wrap resp=%0b rdata=%h",
                 addr, rd, wr, sat_resp, sat_rdata, wrp_resp, wrp_rdata);
    endtask

    // Drive mask m for n consecutive clock edges, then drop to zero.
    task automatic pulse(input logic [8:0] m, input int n);
        @(negedge clk);
        events = m;
        repeat (n) @(negedge clk);
        events = '0;
    endtask

    initial begin
        logic        h, r;
        logic [15:0] d;

        reset_n = 1'b0; events = '0; freeze = 1'b0;
        bus_addr = 16'h0000; bus_read = 1'b0; bus_write = 1'b0; bus_wdata = '0;
        s_events = '0; s_addr = 16'h0000; s_read = 1'b0; s_write = 1'b0; s_wdata = '0;

        repeat (2) @(negedge clk);
        check("reset resp", 16'(bus_resp), 16'h0000);
        check("reset rdata", bus_rdata, 16'h0000);
        reset_n = 1'b1;

        rd_chk("reset cnt0", 16'hFF00, 16'h0000);
        rd_chk("reset cfg0", 16'hFF12, 16'h0000);

        // Cycle mode on channel 0
        wr_op(16'hFF12, 16'h0000);
        pulse(9'h001, 5);
        bus_op(16'hFF00, 1'b1, 1'b0, 16'h0000, h, r, d);
        check("cycles hit", 16'(h), 16'h0001);
        check("cycles resp", 16'(r), 16'h0001);
        check("cycles cnt0", d, 16'h0005);
        @(negedge clk);
        check("resp pulse end", 16'(bus_resp), 16'h0000);

        // Run mode on channel 1, thresh 2
        wr_op(16'hFF14, 16'h1002);
        rd_chk("runs cfg1", 16'hFF14, 16'h1002);
        pulse(9'h002, 1);
        pulse(9'h002, 3);
        pulse(9'h002, 2);
        pulse(9'h002, 6);
        rd_chk("runs cnt1", 16'hFF02, 16'h0002);
        rd_chk("odd addr cnt1", 16'hFF03, 16'h0002);

        // Counter write collides with an event: increment dropped
        @(negedge clk);
        bus_addr = 16'hFF04; bus_write = 1'b1; bus_wdata = 16'h0007; events = 9'h004;
        @(negedge clk);
        check("wr resp", 16'(bus_resp), 16'h0001);
        check("wr prevalue", bus_rdata, 16'h0000);
        bus_write = 1'b0; events = '0;
        rd_chk("wr drop cnt2", 16'hFF04, 16'h0007);
        pulse(9'h004, 1);
        rd_chk("after wr cnt2", 16'hFF04, 16'h0008);

        // Read and write together behave as write, returning the old value
        bus_op(16'hFF00, 1'b1, 1'b1, 16'h0020, h, r, d);
        check("rw resp", 16'(r), 16'h0001);
        check("rw prevalue", d, 16'h0005);
        rd_chk("rw cnt0", 16'hFF00, 16'h0020);

        // Freeze with all events high
        @(negedge clk);
        freeze = 1'b1; events = 9'h1FF;
        repeat (4) @(negedge clk);
        freeze = 1'b0; events = '0;
        rd_chk("freeze cnt0", 16'hFF00, 16'h0020);
        rd_chk("freeze cnt1", 16'hFF02, 16'h0002);
        rd_chk("freeze cnt2", 16'hFF04, 16'h0008);
        rd_chk("freeze cnt8", 16'hFF10, 16'h0000);

        // Window edges
        rd_chk("last cfg8", 16'hFF22, 16'h0000);
        bus_op(16'hFF24, 1'b1, 1'b0, 16'h0000, h, r, d);
        check("miss above hit", 16'(h), 16'h0000);
        check("miss above resp", 16'(r), 16'h0000);
        bus_op(16'hFEFE, 1'b1, 1'b1, 16'h1234, h, r, d);
        check("miss below hit", 16'(h), 16'h0000);
        check("miss below resp", 16'(r), 16'h0000);
        rd_chk("miss no write", 16'hFF00, 16'h0020);

        // 4-bit overflow: saturate vs wrap
        @(negedge clk);
        s_events = 1'b1;
        repeat (20) @(negedge clk);
        s_events = 1'b0;
        s_op(16'hFF00, 1'b1, 1'b0, 16'h0000);
        check("sat resp", 16'(sat_resp), 16'h0001);
        check("sat cnt", sat_rdata, 16'h000F);
        check("wrap cnt", wrp_rdata, 16'h0004);
        s_op(16'hFF02, 1'b1, 1'b0, 16'h0000);
        check("sat ovf set", sat_rdata, 16'h8000);
        check("wrap ovf set", wrp_rdata, 16'h8000);
        s_op(16'hFF02, 1'b0, 1'b1, 16'h8000);
        s_op(16'hFF02, 1'b1, 1'b0, 16'h0000);
        check("sat ovf clr", sat_rdata, 16'h0000);
        check("wrap ovf clr", wrp_rdata, 16'h0000);
        s_op(16'hFF00, 1'b1, 1'b0, 16'h0000);
        check("sat cnt kept", sat_rdata, 16'h000F);
        check("wrap cnt kept", wrp_rdata, 16'h0004);

        // Asynchronous reset mid-run with a response in flight
        wr_op(16'hFF14, 16'h1000);
        @(negedge clk);
        events = 9'h002; bus_addr = 16'hFF00; bus_read = 1'b1;
        @(posedge clk);
        #1;
        check("pre-reset resp", 16'(bus_resp), 16'h0001);
        check("pre-reset rdata", bus_rdata, 16'h0020);
        #1 reset_n = 1'b0;
        #1;
        check("async resp", 16'(bus_resp), 16'h0000);
        check("async rdata", bus_rdata, 16'h0000);
        @(negedge clk);
        events = '0; bus_read = 1'b0;
        @(negedge clk);
        reset_n = 1'b1; bus_addr = 16'hFF02; bus_read = 1'b1;
        @(negedge clk);
        check("first req resp", 16'(bus_resp), 16'h0001);
        check("post-reset cnt1", bus_rdata, 16'h0000);
        bus_read = 1'b0;
        rd_chk("post-reset cnt0", 16'hFF00, 16'h0000);
        rd_chk("post-reset cfg1", 16'hFF14, 16'h0000);
        wr_op(16'hFF14, 16'h1000);
        pulse(9'h002, 4);
        rd_chk("thresh0 run", 16'hFF02, 16'h0001);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
